// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target holding a small 32-bit register file.
// Decodes cmd/addr/data frames sampled in the clk domain and returns read data on miso.
module spi_slave_regfile #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = 3,
    parameter logic [31:0] RST_VAL  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sclk,
    input  logic                     cs,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     wr_valid,
    output logic [IDX_W-1:0]         wr_idx,
    output logic [31:0]              wr_data,
    output logic [NUM_REGS*32-1:0]   regs_flat,
    output logic                     frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic             r_cs_s1, r_cs_s2, r_cs_s3;
    logic             r_mosi_s1, r_mosi_s2;
    logic             r_post;
    logic             r_armed;
    logic [5:0]       r_cnt;
    logic             r_cmd;
    logic [31:0]      r_shift;
    logic [31:0]      r_tx;
    logic [IDX_W-1:0] r_idx;
    logic             r_wr_pend;
    logic [31:0]      r_regs [NUM_REGS];

    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_cs_rise;
    logic             w_cs_fall;
    logic [31:0]      w_shift_next;

    assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall  = ~r_sclk_s2 & r_sclk_s3;
    assign w_cs_rise    = r_cs_s2 & ~r_cs_s3;
    assign w_cs_fall    = ~r_cs_s2 & r_cs_s3 & r_armed;
    assign w_shift_next = {r_shift[30:0], r_mosi_s2};

    always_comb begin
        regs_flat = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_flat[32*k +: 32] = r_regs[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_post    <= 1'b0;
            r_armed   <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cmd     <= 1'b0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_idx     <= '0;
            r_wr_pend <= 1'b0;
            miso      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_idx    <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RST_VAL;
            end
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= cs;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;

            // The cs chain resets high, so a cs held low through reset would look
            // like a fresh fall; only accept falls once cs has really been seen high.
            r_post <= 1'b1;
            if (r_post && r_cs_s1 && r_cs_s2 && r_cs_s3) begin
                r_armed <= 1'b1;
            end

            if (r_wr_pend) begin
                r_wr_pend      <= 1'b0;
                r_regs[r_idx]  <= r_shift;
                wr_valid       <= 1'b1;
                wr_idx         <= r_idx;
                wr_data        <= r_shift;
            end

            if (w_cs_rise) begin
                if (r_state != S_IDLE && r_state != S_DONE) begin
                    frame_err <= 1'b1;
                end
                r_state <= S_IDLE;
                r_cnt   <= '0;
                miso    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        miso <= 1'b0;
                        if (w_cs_fall) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd   <= r_mosi_s2;
                            r_state <= S_ADDR;
                            r_cnt   <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next;
                            if (r_cnt == 6'd15) begin
                                r_idx   <= w_shift_next[IDX_W+1:2];
                                r_state <= r_cmd ? S_WDATA : S_RDATA;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next;
                            if (r_cnt == 6'd31) begin
                                r_state   <= S_DONE;
                                r_wr_pend <= 1'b1;
                                r_cnt     <= '0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        // The first fall precedes any data rise, so cnt==0 marks the load.
                        if (w_sclk_fall) begin
                            if (r_cnt == 6'd0) begin
                                r_tx <= r_regs[r_idx];
                                miso <= r_regs[r_idx][31];
                            end else begin
                                r_tx <= {r_tx[30:0], 1'b0};
                                miso <= r_tx[30];
                            end
                        end else if (w_sclk_rise) begin
                            if (r_cnt == 6'd31) begin
                                r_state <= S_DONE;
                                r_cnt   <= '0;
                                miso    <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        miso <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        miso    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
